// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - rising-edge period / high-time meter with valid/ready result and overrun/timeout flags
//
// Measures the distance between consecutive rising edges of IN, and how many
// of those cycles IN was high, and hands each finished measurement to a
// downstream consumer through a one-deep valid/ready output register.
//
// Parameters
//   CNT_W     width of the period / high-time counters and result outputs
//   TIMEOUT   cycles without a rising edge before TIMEOUT_O is raised (0 = off)
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   IN         in   measured waveform, synchronous to CLK
//   EN         in   measurement enable; low returns to IDLE and clears flags
//   PERIOD     out  cycles between two consecutive rising edges
//   HIGH       out  cycles IN was high within that period
//   VALID      out  PERIOD/HIGH hold an unconsumed result
//   READY      in   consumer accepts the result
//   OVERRUN    out  sticky: a result was dropped because the last one was unread
//   TIMEOUT_O  out  level: no rising edge within TIMEOUT cycles

module pulse_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN,
  input  logic             EN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH,
  output logic             VALID,
  input  logic             READY,
  output logic             OVERRUN,
  output logic             TIMEOUT_O
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic             TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic             in_q,       in_d;
  logic [CNT_W-1:0] per_cnt_q,  per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  logic [CNT_W-1:0] high_q,     high_d;
  logic             valid_q,    valid_d;
  logic             overrun_q,  overrun_d;
  logic             timeout_q,  timeout_d;

  logic rise;
  logic capture;

  always_comb begin
    state_d    = state_q;
    in_d       = IN;
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    capture    = 1'b0;

    // Edge seen in the same cycle IN is first sampled high.
    rise = IN & ~in_q;

    if (!EN) begin
      state_d    = S_IDLE;
      per_cnt_d  = '0;
      high_cnt_d = '0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          per_cnt_d  = '0;
          high_cnt_d = '0;
          state_d    = S_ARM;
        end

        S_ARM: begin
          // The first edge only opens a measurement window.
          if (rise) begin
            state_d    = S_MEASURE;
            per_cnt_d  = CNT_ONE;
            high_cnt_d = CNT_ONE;
            timeout_d  = 1'b0;
          end
        end

        S_MEASURE: begin
          // A rise beats a coincident timeout: the window closed in time.
          if (rise) begin
            capture    = 1'b1;
            per_cnt_d  = CNT_ONE;
            high_cnt_d = CNT_ONE;
            timeout_d  = 1'b0;
          end else if (TIMEOUT_EN && (per_cnt_q == TIMEOUT_CNT)) begin
            state_d    = S_ARM;
            per_cnt_d  = '0;
            high_cnt_d = '0;
            timeout_d  = 1'b1;
          end else begin
            // Saturate instead of wrapping so overlong periods read as max.
            if (per_cnt_q != CNT_MAX) begin
              per_cnt_d = per_cnt_q + CNT_ONE;
            end
            if (IN && (high_cnt_q != CNT_MAX)) begin
              high_cnt_d = high_cnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // One-deep result register: an unread result is never overwritten.
    if (capture) begin
      if (!valid_q || READY) begin
        period_d = per_cnt_q;
        high_d   = high_cnt_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      in_q       <= 1'b0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign PERIOD    = period_q;
  assign HIGH      = high_q;
  assign VALID     = valid_q;
  assign OVERRUN   = overrun_q;
  assign TIMEOUT_O = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - self-checking bench for pulse_period_meter against a timestamp-based model
module tb_pulse_period_meter;

  localparam int MX [2] = '{255, 15};
  localparam int TM [2] = '{20, 0};

  logic       clk;
  logic       rst_n;
  logic       in_v;
  logic       en_v;
  logic       ready_v;
  logic [7:0] per_a, high_a;
  logic [3:0] per_b, high_b;
  logic       valid_a, ovr_a, tmo_a;
  logic       valid_b, ovr_b, tmo_b;

  pulse_period_meter #(.CNT_W(8), .TIMEOUT(20)) dut_a (
    .CLK(clk), .RST(rst_n), .IN(in_v), .EN(en_v),
    .PERIOD(per_a), .HIGH(high_a), .VALID(valid_a), .READY(ready_v),
    .OVERRUN(ovr_a), .TIMEOUT_O(tmo_a)
  );

  pulse_period_meter #(.CNT_W(4), .TIMEOUT(0)) dut_b (
    .CLK(clk), .RST(rst_n), .IN(in_v), .EN(en_v),
    .PERIOD(per_b), .HIGH(high_b), .VALID(valid_b), .READY(ready_v),
    .OVERRUN(ovr_b), .TIMEOUT_O(tmo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model: mode 0 idle, 1 waiting for first edge, 2 measuring since m_rt.
  int cyc = 0;
  bit m_inprev;
  int m_mode [2];
  int m_rt   [2];
  int m_hs   [2];
  int m_per  [2];
  int m_high [2];
  bit m_valid[2];
  bit m_ovr  [2];
  bit m_tmo  [2];

  int exp_p, exp_h, va_hits, vb_hits;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_inprev = 0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_rt[i] = 0; m_hs[i] = 0; m_per[i] = 0; m_high[i] = 0;
      m_valid[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit rise);
    bit cap;
    int p, hh;
    cap = 0; p = 0; hh = 0;
    if (!en_v) begin
      m_mode[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
    end else if (m_mode[i] == 0) begin
      m_mode[i] = 1;
    end else if (m_mode[i] == 1) begin
      if (rise) begin
        m_mode[i] = 2; m_rt[i] = cyc; m_hs[i] = 1; m_tmo[i] = 0;
      end
    end else begin
      if (rise) begin
        cap = 1;
        p   = imin(cyc - m_rt[i], MX[i]);
        hh  = imin(m_hs[i], MX[i]);
        m_rt[i] = cyc; m_hs[i] = 1; m_tmo[i] = 0;
      end else if (TM[i] != 0 && (cyc - m_rt[i]) == TM[i]) begin
        m_mode[i] = 1; m_tmo[i] = 1;
      end else begin
        m_hs[i] += int'(in_v);
      end
    end
    if (cap) begin
      if (!m_valid[i] || ready_v) begin
        m_per[i] = p; m_high[i] = hh; m_valid[i] = 1;
      end else begin
        m_ovr[i] = 1;
      end
    end else if (m_valid[i] && ready_v) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic model_step_all();
    bit rise;
    if (!rst_n) begin
      model_reset();
    end else begin
      rise = in_v && !m_inprev;
      model_step(0, rise);
      model_step(1, rise);
      m_inprev = in_v;
    end
    cyc++;
  endtask

  // One clock cycle: inputs applied mid-cycle, model advanced on the edge.
  task automatic drive(input logic i, input logic e, input logic r);
    if (valid_a && r && int'(per_a) == exp_p && int'(high_a) == exp_h) va_hits++;
    if (valid_b && r && int'(per_b) == exp_p && int'(high_b) == exp_h) vb_hits++;
    in_v = i; en_v = e; ready_v = r;
    @(posedge clk);
    model_step_all();
    #1;
  endtask

  task automatic wave(input int h, input int l, input int n, input logic r);
    repeat (n) begin
      repeat (h) drive(1'b1, 1'b1, r);
      repeat (l) drive(1'b0, 1'b1, r);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input int p, input int h, input int v, input int o, input int t);
    checks++;
    if (p != m_per[i] || h != m_high[i] || v != int'(m_valid[i]) || o != int'(m_ovr[i]) || t != int'(m_tmo[i])) begin
      errors++;
      $display("FAIL model_cmp dut%0d t=%0t: got per=%0d high=%0d valid=%0d ovr=%0d tmo=%0d expected per=%0d high=%0d valid=%0d ovr=%0d tmo=%0d",
               i, $time, p, h, v, o, t, m_per[i], m_high[i], m_valid[i], m_ovr[i], m_tmo[i]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, int'(per_a), int'(high_a), int'(valid_a), int'(ovr_a), int'(tmo_a));
      cmp(1, int'(per_b), int'(high_b), int'(valid_b), int'(ovr_b), int'(tmo_b));
    end
  end

  function automatic logic rnd_ready();
    return ($urandom_range(0, 3) != 0);
  endfunction

  int kind, h, l, n;

  initial begin
    rst_n = 1'b0; in_v = 1'b0; en_v = 1'b0; ready_v = 1'b0;
    exp_p = 8; exp_h = 3; va_hits = 0; vb_hits = 0;
    model_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("reset_valid_a", int'(valid_a), 0);
    chk("reset_period_a", int'(per_a), 0);
    chk("reset_flags_b", int'({ovr_b, tmo_b, valid_b}), 0);
    chk_on = 1;
    rst_n = 1'b1;

    // 3 high / 5 low square wave, always ready
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    wave(3, 5, 6, 1'b1);
    chk("square_hits_a", va_hits, 5);
    chk("square_hits_b", vb_hits, 5);
    chk("square_no_overrun", int'(ovr_a), 0);

    // consumer stalled: first result held, second dropped
    wave(3, 5, 1, 1'b0);
    wave(3, 4, 1, 1'b0);
    chk("stall_valid", int'(valid_a), 1);
    chk("stall_period", int'(per_a), 8);
    chk("stall_overrun", int'(ovr_a), 1);
    drive(1'b0, 1'b1, 1'b1);
    chk("stall_drain", int'(valid_a), 0);
    wave(3, 5, 1, 1'b0);
    chk("stall_next_period", int'(per_a), 8);
    chk("stall_next_high", int'(high_a), 3);
    drive(1'b0, 1'b0, 1'b1);
    chk("en_clears_overrun", int'(ovr_a), 0);

    // single edge then stuck low: timeout after 20 cycles on dut_a only
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    repeat (17) drive(1'b0, 1'b1, 1'b1);
    chk("timeout_not_yet", int'(tmo_a), 0);
    drive(1'b0, 1'b1, 1'b1);
    chk("timeout_set", int'(tmo_a), 1);
    chk("timeout_no_valid", int'(valid_a), 0);
    chk("timeout_disabled_b", int'(tmo_b), 0);
    repeat (5) drive(1'b0, 1'b1, 1'b1);
    chk("timeout_level", int'(tmo_a), 1);
    drive(1'b1, 1'b1, 1'b1);
    chk("timeout_cleared_by_rise", int'(tmo_a), 0);
    repeat (2) drive(1'b1, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b1);
    chk("resume_no_valid_yet", int'(valid_a), 0);
    va_hits = 0;
    wave(3, 5, 2, 1'b1);
    chk("resume_hits_a", va_hits, 2);

    // saturation on the 4-bit instance: period 30, high 20
    exp_p = 15; exp_h = 15; vb_hits = 0;
    wave(20, 10, 3, 1'b1);
    chk("saturate_hits_b", vb_hits, 2);
    chk("long_period_timeout_a", int'(tmo_a), 1);

    // drop EN mid-period with a result pending
    wave(3, 5, 3, 1'b0);
    repeat (2) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("en_drop_valid_kept", int'(valid_a), 1);
    chk("en_drop_period_kept", int'(per_a), 8);
    chk("en_drop_overrun_clr", int'(ovr_a), 0);
    chk("en_drop_b_period", int'(per_b), 15);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("en_drop_drained", int'(valid_a), 0);

    // asynchronous reset in the middle of a measurement
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    wave(3, 5, 3, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", int'(valid_a), 0);
    chk("async_rst_period", int'(per_a), 0);
    chk("async_rst_high", int'(high_a), 0);
    chk("async_rst_overrun", int'(ovr_a), 0);
    chk("async_rst_b", int'({valid_b, ovr_b, per_b}), 0);
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;

    // randomized segments, checked every cycle by the model compare
    for (int s = 0; s < 220; s++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: repeat ($urandom_range(15, 40)) drive(1'b0, 1'b1, rnd_ready());
        1: repeat ($urandom_range(1, 3)) drive(1'($urandom_range(0, 1)), 1'b0, rnd_ready());
        2: begin
          rst_n = 1'b0;
          model_reset();
          drive(1'b0, 1'b1, 1'b0);
          rst_n = 1'b1;
        end
        3: repeat (10) drive(1'($urandom_range(0, 1)), 1'b1, rnd_ready());
        default: begin
          h = $urandom_range(1, 12);
          l = $urandom_range(1, 12);
          n = $urandom_range(1, 4);
          repeat (n) begin
            repeat (h) drive(1'b1, 1'b1, rnd_ready());
            repeat (l) drive(1'b0, 1'b1, rnd_ready());
          end
        end
      endcase
    end

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
